tile_map_engine: RTL and testbench
==================================

// Module: tile_map_engine
// PURPOSE
//  RAM-backed, parametrised tile map. Replaces fixed combinational wall decoding with a per-level grid.
//  Grid is loaded from an internal layout generator. Two read clients, one write client:
//  - video render lookup (pixel coords -> tile code)
//  - car/physics collision query (handshaked)
//  - pickup-clear port (fuel/flag consumed by the car)
//  Sits between the level controller and both the VGA pixel pipeline and the car motion logic.
// PARAMETERS
//  TILE_SHIFT  5   log2 tile edge in pixels (32x32 tiles)
//  GRID_W      20  tiles per row
//  GRID_H      15  tiles per column
//  PIX_W       10  pixel coordinate width
//  LVL_W       2   level_id width
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-high reset
//  level_id      in   LVL_W  level to load, sampled on load_start
//  load_start    in   1      1-cycle pulse: rebuild grid for level_id
//  busy          out  1      high while LOAD runs
//  load_done     out  1      1-cycle pulse on the last LOAD write
//  xPixel        in   PIX_W  render lookup X
//  yPixel        in   PIX_W  render lookup Y
//  tile_code     out  2      registered tile at (xPixel,yPixel): 0 empty, 1 wall, 2 fuel, 3 flag
//  is_wall       out  1      registered, = (tile_code==1)
//  q_valid       in   1      collision query request
//  q_ready       out  1      query accepted when q_valid&&q_ready
//  q_x           in   PIX_W  query pixel X
//  q_y           in   PIX_W  query pixel Y
//  q_resp_valid  out  1      1-cycle pulse with the result
//  q_tile        out  2      query result tile code
//  clr_valid     in   1      clear request (no backpressure)
//  clr_gx        in   5      clear grid X
//  clr_gy        in   5      clear grid Y
//  pickups_left  out  9      remaining fuel+flag tiles (see CONFIGURATION)
//  level_clear   out  1      1-cycle pulse when pickups_left reaches 0
// BEHAVIOUR
//  Reset:
//   - state=LOAD, level latch=0, cell index=0, busy=1
//   - tile_code=1, is_wall=1, q_tile=0, q_resp_valid=0, load_done=0, level_clear=0, pickups_left=0
//  Grid mapping: gx=pixel>>TILE_SHIFT, gy=pixel>>TILE_SHIFT.
//   - gx>=GRID_W or gy>=GRID_H reads as wall; clears to such cells are ignored.
//  FSM IDLE/LOAD:
//   - IDLE->LOAD on load_start: latch level_id, index=0.
//   - LOAD writes one cell per cycle in row-major order: gx fastest, GRID_W*GRID_H cycles total.
//   - LOAD->IDLE after cell (GRID_W-1,GRID_H-1); load_done pulses in that same cycle.
//   - load_start during LOAD: restart at index 0 with the new level_id; no load_done for the aborted load.
//  Layout generator, evaluated per written cell:
//   - wall on the border: gx=0, gx=GRID_W-1, gy=0, gy=GRID_H-1
//   - wall on the HUD block: gx in GRID_W-5..GRID_W-2, gy in GRID_H-3..GRID_H-2
//   - level 0: no other content
//   - level 1: wall at gx=10, gy 3..11
//   - levels 2,3: wall tables held in the layout function
//   - levels 1-3: fuel at (2,2), (GRID_W-3,2), (2,GRID_H-3); flag at (GRID_W-3,GRID_H-5)
//   - priority: wall > flag > fuel > empty
//  Render path:
//   - 1-cycle latency: tile_code/is_wall reflect the xPixel/yPixel presented on the previous clock
//   - while busy, both outputs are forced to wall
//  Query path:
//   - q_ready = (state==IDLE)
//   - accepted query returns q_tile with q_resp_valid exactly one cycle later
//   - back-to-back queries are sustained at one per cycle
//   - q_tile holds its value between responses
//  Clear path:
//   - in IDLE, a cell holding 2 or 3 is written to 0 on the next clock
//   - walls and empty cells are unchanged
//   - ignored entirely while busy
//  Same-cycle query and clear to the same cell: query returns the pre-clear value (read-before-write).
// CONFIGURATION
//  TILE_MAP_PICKUP_COUNT_EN
//   defined:
//    - LOAD counts pickup cells written; pickups_left is valid from load_done
//    - each effective clear decrements pickups_left
//    - level_clear pulses on the decrement 1->0, never after a load that yields 0 pickups
//    - counter saturates at 0
//   undefined: pickups_left tied to 0, level_clear tied to 0, no counter logic.
// TESTING
//  - reset, hold 300 cycles -> busy falls at cycle 300, load_done 1 pulse; is_wall=1 throughout LOAD
//  - level 1 loaded; xPixel=320,yPixel=96 -> is_wall=1 next cycle; (352,96) -> 0; (64,64) -> tile_code=2
//  - q_valid at (64,64) with clr at (2,2) same cycle -> q_tile=2; repeat query -> q_tile=0
//  - clr on wall (10,5) -> query returns 1; clr while busy -> no effect after load
//  - load_start at LOAD index 150 with level 2 -> load_done 300 cycles later; level-2 walls present
//  - PICKUP_COUNT_EN, level 1: pickups_left=4; clear all 4 -> level_clear pulses once; extra clear stays 0

Source files
------------

// File: rtl/tile_map_engine.sv
// RAM-backed tile map: per-level grid builder, registered render lookup, handshaked collision query, pickup clear.
// Optional pickup counter enabled by defining TILE_MAP_PICKUP_COUNT_EN.
module tile_map_engine #(
    parameter int TILE_SHIFT = 5,
    parameter int GRID_W     = 20,
    parameter int GRID_H     = 15,
    parameter int PIX_W      = 10,
    parameter int LVL_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LVL_W-1:0] level_id,
    input  logic             load_start,
    output logic             busy,
    output logic             load_done,
    input  logic [PIX_W-1:0] xPixel,
    input  logic [PIX_W-1:0] yPixel,
    output logic [1:0]       tile_code,
    output logic             is_wall,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [PIX_W-1:0] q_x,
    input  logic [PIX_W-1:0] q_y,
    output logic             q_resp_valid,
    output logic [1:0]       q_tile,
    input  logic             clr_valid,
    input  logic [4:0]       clr_gx,
    input  logic [4:0]       clr_gy,
    output logic [8:0]       pickups_left,
    output logic             level_clear
);

    localparam int CELLS  = GRID_W * GRID_H;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int G_W    = 5;

    localparam logic [1:0] T_EMPTY = 2'd0;
    localparam logic [1:0] T_WALL  = 2'd1;
    localparam logic [1:0] T_FUEL  = 2'd2;
    localparam logic [1:0] T_FLAG  = 2'd3;

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    state_t           state, state_next;
    logic [LVL_W-1:0] level_q, level_next;
    logic [G_W-1:0]   ld_gx, ld_gy, ld_gx_next, ld_gy_next;
    logic             ld_last;
    logic [1:0]       ld_tile;
    logic [1:0]       render_tile;
    logic             q_accept;
    logic             clr_in_range;
    logic [ADDR_W-1:0] clr_addr;
    logic             clr_hit;

    logic [1:0] mem [CELLS];

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [G_W-1:0] gx, input logic [G_W-1:0] gy);
        return ADDR_W'(gy) * ADDR_W'(GRID_W) + ADDR_W'(gx);
    endfunction

    // Cells outside the grid always read back as wall.
    function automatic logic [1:0] pix_read(input logic [PIX_W-1:0] px, input logic [PIX_W-1:0] py);
        logic [PIX_W-1:0] gx, gy;
        gx = px >> TILE_SHIFT;
        gy = py >> TILE_SHIFT;
        if (int'(gx) >= GRID_W || int'(gy) >= GRID_H)
            return T_WALL;
        return mem[cell_addr(G_W'(gx), G_W'(gy))];
    endfunction

    function automatic logic [1:0] layout(input logic [LVL_W-1:0] lvl, input logic [G_W-1:0] gx,
                                          input logic [G_W-1:0] gy);
        int   x, y;
        logic wall, fuel, flag;
        x    = int'(gx);
        y    = int'(gy);
        wall = (x == 0) || (x == GRID_W-1) || (y == 0) || (y == GRID_H-1) ||
               (x >= GRID_W-5 && x <= GRID_W-2 && y >= GRID_H-3 && y <= GRID_H-2);
        case (int'(lvl))
            1:       wall = wall || (x == 10 && y >= 3 && y <= 11);
            2:       wall = wall || (y == 7 && x >= 4 && x <= 15) || (x == 14 && y >= 3 && y <= 6);
            3:       wall = wall || ((x == 5 || x == 14) && y >= 3 && y <= 11) ||
                            (y == 5 && x >= 7 && x <= 12);
            default: wall = wall;
        endcase
        fuel = (lvl != '0) && ((x == 2 && y == 2) || (x == GRID_W-3 && y == 2) ||
                               (x == 2 && y == GRID_H-3));
        flag = (lvl != '0) && (x == GRID_W-3 && y == GRID_H-5);
        if (wall) return T_WALL;
        if (flag) return T_FLAG;
        if (fuel) return T_FUEL;
        return T_EMPTY;
    endfunction

    assign busy     = (state == S_LOAD);
    assign q_ready  = (state == S_IDLE);
    assign q_accept = q_valid && q_ready;
    assign ld_last  = (state == S_LOAD) && (int'(ld_gx) == GRID_W-1) && (int'(ld_gy) == GRID_H-1);
    assign ld_tile  = layout(level_q, ld_gx, ld_gy);

    assign render_tile  = pix_read(xPixel, yPixel);
    assign clr_in_range = (int'(clr_gx) < GRID_W) && (int'(clr_gy) < GRID_H);
    assign clr_addr     = cell_addr(clr_gx, clr_gy);
    assign clr_hit      = (state == S_IDLE) && clr_valid && clr_in_range && mem[clr_addr][1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_LOAD;
            level_q <= '0;
            ld_gx   <= '0;
            ld_gy   <= '0;
        end else begin
            state   <= state_next;
            level_q <= level_next;
            ld_gx   <= ld_gx_next;
            ld_gy   <= ld_gy_next;
        end
    end

    // A load_start always restarts from cell 0, aborting any load in flight.
    always_comb begin
        state_next = state;
        level_next = level_q;
        ld_gx_next = ld_gx;
        ld_gy_next = ld_gy;
        load_done  = 1'b0;
        if (load_start) begin
            state_next = S_LOAD;
            level_next = level_id;
            ld_gx_next = '0;
            ld_gy_next = '0;
        end else if (state == S_LOAD) begin
            if (ld_last) begin
                state_next = S_IDLE;
                load_done  = 1'b1;
                ld_gx_next = '0;
                ld_gy_next = '0;
            end else if (int'(ld_gx) == GRID_W-1) begin
                ld_gx_next = '0;
                ld_gy_next = ld_gy + 1'b1;
            end else begin
                ld_gx_next = ld_gx + 1'b1;
            end
        end
    end

    // NOTE: the grid RAM has no reset; the LOAD that follows reset rewrites every cell.
    always_ff @(posedge clk) begin
        if (state == S_LOAD)
            mem[cell_addr(ld_gx, ld_gy)] <= ld_tile;
        else if (clr_hit)
            mem[clr_addr] <= T_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tile_code    <= T_WALL;
            is_wall      <= 1'b1;
            q_tile       <= T_EMPTY;
            q_resp_valid <= 1'b0;
        end else begin
            tile_code    <= busy ? T_WALL : render_tile;
            is_wall      <= busy || (render_tile == T_WALL);
            q_resp_valid <= q_accept;
            if (q_accept)
                q_tile <= pix_read(q_x, q_y);
        end
    end

`ifdef TILE_MAP_PICKUP_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pickups_left <= '0;
            level_clear  <= 1'b0;
        end else begin
            level_clear <= 1'b0;
            if (load_start) begin
                pickups_left <= '0;
            end else if (state == S_LOAD) begin
                if (ld_tile[1])
                    pickups_left <= pickups_left + 1'b1;
            end else if (clr_hit && pickups_left != '0) begin
                pickups_left <= pickups_left - 1'b1;
                level_clear  <= (pickups_left == 9'd1);
            end
        end
    end
`else
    assign pickups_left = '0;
    assign level_clear  = 1'b0;
`endif

endmodule

// File: tb/tb_tile_map_engine.sv
// Self-checking bench for tile_map_engine: vector table, hand sequences, randomized traffic against a grid model.
module tb_tile_map_engine;

    localparam int GW = 20;
    localparam int GH = 15;
`ifdef TILE_MAP_PICKUP_COUNT_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [1:0] level_id;
    logic       load_start;
    logic       busy, load_done;
    logic [9:0] xPixel, yPixel;
    logic [1:0] tile_code;
    logic       is_wall;
    logic       q_valid, q_ready;
    logic [9:0] q_x, q_y;
    logic       q_resp_valid;
    logic [1:0] q_tile;
    logic       clr_valid;
    logic [4:0] clr_gx, clr_gy;
    logic [8:0] pickups_left;
    logic       level_clear;

    tile_map_engine dut (
        .clk(clk), .reset(reset), .level_id(level_id), .load_start(load_start),
        .busy(busy), .load_done(load_done), .xPixel(xPixel), .yPixel(yPixel),
        .tile_code(tile_code), .is_wall(is_wall), .q_valid(q_valid), .q_ready(q_ready),
        .q_x(q_x), .q_y(q_y), .q_resp_valid(q_resp_valid), .q_tile(q_tile),
        .clr_valid(clr_valid), .clr_gx(clr_gx), .clr_gy(clr_gy),
        .pickups_left(pickups_left), .level_clear(level_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int model [GH][GW];

    typedef struct {
        int px;
        int py;
        int code;
    } rvec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void place(int x, int y, int code);
        if (model[y][x] == 0) model[y][x] = code;
    endfunction

    // Paint the level from its description: empty field, walls, then pickups into free cells.
    function automatic void build_model(int lvl);
        foreach (model[y, x]) model[y][x] = 0;
        for (int x = 0; x < GW; x++) begin
            model[0][x]    = 1;
            model[GH-1][x] = 1;
        end
        for (int y = 0; y < GH; y++) begin
            model[y][0]    = 1;
            model[y][GW-1] = 1;
        end
        for (int y = GH-3; y <= GH-2; y++)
            for (int x = GW-5; x <= GW-2; x++) model[y][x] = 1;
        if (lvl == 1)
            for (int y = 3; y <= 11; y++) model[y][10] = 1;
        if (lvl == 2) begin
            for (int x = 4; x <= 15; x++) model[7][x] = 1;
            for (int y = 3; y <= 6; y++) model[y][14] = 1;
        end
        if (lvl == 3) begin
            for (int y = 3; y <= 11; y++) begin
                model[y][5]  = 1;
                model[y][14] = 1;
            end
            for (int x = 7; x <= 12; x++) model[5][x] = 1;
        end
        if (lvl != 0) begin
            place(GW-3, GH-5, 3);
            place(2, 2, 2);
            place(GW-3, 2, 2);
            place(2, GH-3, 2);
        end
    endfunction

    function automatic int lookup_pix(int px, int py);
        int gx = px >> 5;
        int gy = py >> 5;
        if (gx >= GW || gy >= GH) return 1;
        return model[gy][gx];
    endfunction

    function automatic int pickups();
        int n = 0;
        foreach (model[y, x]) if (model[y][x] >= 2) n++;
        return n;
    endfunction

    task automatic start_load(input int lvl);
        level_id   = 2'(lvl);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        level_id   = ~2'(lvl);
        build_model(lvl);
    endtask

    // Observe a LOAD from the current cycle until busy drops (bounded).
    task automatic run_load(input string tag, input int exp_cycles);
        int busy_cycles = 0;
        int done_count  = 0;
        int done_at     = -1;
        int bad         = 0;
        for (int c = 0; c < 400 && busy === 1'b1; c++) begin
            busy_cycles++;
            if (load_done === 1'b1) begin
                done_count++;
                done_at = c;
            end
            if ((c > 0 && is_wall !== 1'b1) || q_ready !== 1'b0 || level_clear !== 1'b0) bad++;
            tick();
        end
        check({tag, "_busy_cycles"}, busy_cycles, exp_cycles);
        check({tag, "_done_pulses"}, done_count, 1);
        check({tag, "_done_cycle"}, done_at, exp_cycles - 1);
        check({tag, "_wall_during_load"}, bad, 0);
        check({tag, "_pickups_after_load"}, pickups_left, PC_EN ? pickups() : 0);
    endtask

    task automatic query(input int px, input int py, input string tag, input int exp);
        q_valid = 1'b1;
        q_x     = 10'(px);
        q_y     = 10'(py);
        tick();
        q_valid = 1'b0;
        check({tag, "_valid"}, q_resp_valid, 1);
        check({tag, "_tile"}, q_tile, exp);
    endtask

    task automatic clear(input int gx, input int gy);
        clr_valid = 1'b1;
        clr_gx    = 5'(gx);
        clr_gy    = 5'(gy);
        tick();
        clr_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rvec_t tbl [15];
        int    early_done;
        int    hold_q;
        int    fx [4];
        int    fy [4];

        tbl[0]  = '{320, 96, 1};
        tbl[1]  = '{352, 96, 0};
        tbl[2]  = '{64, 64, 2};
        tbl[3]  = '{544, 64, 2};
        tbl[4]  = '{64, 384, 2};
        tbl[5]  = '{544, 320, 3};
        tbl[6]  = '{0, 0, 1};
        tbl[7]  = '{639, 479, 1};
        tbl[8]  = '{640, 0, 1};
        tbl[9]  = '{100, 480, 1};
        tbl[10] = '{1023, 1023, 1};
        tbl[11] = '{500, 416, 1};
        tbl[12] = '{160, 160, 0};
        tbl[13] = '{320, 352, 1};
        tbl[14] = '{320, 384, 0};
        fx = '{2, GW-3, 2, GW-3};
        fy = '{2, 2, GH-3, GH-5};

        reset = 1'b1; level_id = '0; load_start = 1'b0;
        xPixel = '0; yPixel = '0; q_valid = 1'b0; q_x = '0; q_y = '0;
        clr_valid = 1'b0; clr_gx = '0; clr_gy = '0;
        repeat (3) tick();

        check("rst_busy", busy, 1);
        check("rst_tile_code", tile_code, 1);
        check("rst_is_wall", is_wall, 1);
        check("rst_q_tile", q_tile, 0);
        check("rst_q_resp_valid", q_resp_valid, 0);
        check("rst_load_done", load_done, 0);
        check("rst_level_clear", level_clear, 0);
        check("rst_pickups_left", pickups_left, 0);
        check("rst_q_ready", q_ready, 0);

        reset = 1'b0;
        build_model(0);
        run_load("reset_load", 300);
        check("lvl0_level_clear", level_clear, 0);

        start_load(1);
        run_load("load1", 300);
        check("idle_q_ready", q_ready, 1);
        for (int i = 0; i < 15; i++) begin
            xPixel = 10'(tbl[i].px);
            yPixel = 10'(tbl[i].py);
            tick();
            check($sformatf("render%0d_code", i), tile_code, tbl[i].code);
            check($sformatf("render%0d_wall", i), is_wall, tbl[i].code == 1);
        end

        // Query and clear of the same cell in one cycle: query sees the pre-clear tile.
        clr_valid = 1'b1; clr_gx = 5'd2; clr_gy = 5'd2;
        query(64, 64, "rbw_first", 2);
        clr_valid = 1'b0;
        model[2][2] = 0;
        query(64, 64, "rbw_repeat", 0);
        tick();
        check("q_idle_no_resp", q_resp_valid, 0);
        check("q_tile_held", q_tile, 0);

        clear(10, 5);
        query(320, 160, "clr_wall", 1);

        start_load(1);
        repeat (100) tick();
        clear(2, 2);
        run_load("busy_clear", 199);
        query(64, 64, "busy_clr_ignored", 2);

        // Abort a load at index 150 and restart with level 2.
        start_load(1);
        early_done = 0;
        for (int i = 0; i < 150; i++) begin
            if (load_done === 1'b1) early_done++;
            tick();
        end
        check("abort_no_done", early_done, 0);
        start_load(2);
        run_load("abort_load2", 300);
        query(448, 224, "lvl2_row7_wall", 1);
        query(448, 128, "lvl2_col14_wall", 1);

        hold_q = 1;
        for (int i = 0; i < 300; i++) begin
            int  qx, qy, rx, ry, cgx, cgy, exp_q, exp_r, prev_left, new_left;
            bit  qv, cv, eff;
            qv = (i == 0) || ($urandom_range(3) != 0);
            cv = ($urandom_range(1) == 1);
            if ($urandom_range(1) == 1) begin
                int k = $urandom_range(3);
                cgx = fx[k];
                cgy = fy[k];
            end else begin
                cgx = $urandom_range(21);
                cgy = $urandom_range(16);
            end
            if ($urandom_range(3) == 0) begin
                qx = cgx * 32 + $urandom_range(31);
                qy = cgy * 32 + $urandom_range(31);
            end else begin
                qx = $urandom_range(720);
                qy = $urandom_range(540);
            end
            rx = $urandom_range(1023);
            ry = $urandom_range(1023);
            q_valid = qv; q_x = 10'(qx); q_y = 10'(qy);
            clr_valid = cv; clr_gx = 5'(cgx); clr_gy = 5'(cgy);
            xPixel = 10'(rx); yPixel = 10'(ry);

            exp_q     = lookup_pix(qx, qy);
            exp_r     = lookup_pix(rx, ry);
            prev_left = pickups();
            eff       = cv && cgx < GW && cgy < GH && model[cgy][cgx] >= 2;
            if (eff) model[cgy][cgx] = 0;
            new_left  = pickups();
            if (qv) hold_q = exp_q;
            tick();

            check("rnd_q_resp_valid", q_resp_valid, qv);
            check("rnd_q_tile", q_tile, hold_q);
            check("rnd_tile_code", tile_code, exp_r);
            check("rnd_is_wall", is_wall, exp_r == 1);
            check("rnd_pickups_left", pickups_left, PC_EN ? new_left : 0);
            check("rnd_level_clear", level_clear, PC_EN && eff && prev_left == 1 && new_left == 0);
        end
        q_valid = 1'b0;
        clr_valid = 1'b0;

        start_load(1);
        run_load("pickup_load1", 300);
        check("pickup_initial", pickups_left, PC_EN ? 4 : 0);
        for (int k = 0; k < 4; k++) begin
            clear(fx[k], fy[k]);
            check($sformatf("pickup_left_%0d", k), pickups_left, PC_EN ? 3 - k : 0);
            check($sformatf("pickup_lvl_clear_%0d", k), level_clear, PC_EN && k == 3);
        end
        tick();
        check("lvl_clear_one_pulse", level_clear, 0);
        clear(2, 2);
        check("extra_clear_left", pickups_left, 0);
        check("extra_clear_no_pulse", level_clear, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
